nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/full_adder_4.sv | 13 +
 rtl/nibble_serial_adder.sv | 134 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble width and the counter-width helper.
package nibble_serial_adder_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cntWidth(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/full_adder_4.sv
// Existing 4-bit ripple full adder stage, reused one nibble per clock by the
// serial adder.
module full_adder_4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);

   assign {c_out, s} = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder (W = 4*NIBBLES) that pushes one nibble per clock
// through a single full_adder_4. Optional signed overflow output: NSA_SIGNED_OVF_EN.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   c_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   s,
`ifdef NSA_SIGNED_OVF_EN
   output logic                   ovf,
`endif
   output logic                   c_out
);

   localparam int W  = NIB_W * NIBBLES;
   localparam int CW = cntWidth(NIBBLES);

   state_t            r_state;
   state_t            w_nextState;
   logic [W-1:0]      r_aSh;
   logic [W-1:0]      r_bSh;
   logic [W-1:0]      r_sSh;
   logic [W-1:0]      r_s;
   logic              r_carry;
   logic              r_cOut;
   logic [CW-1:0]     r_cnt;
   logic [NIB_W-1:0]  w_nibSum;
   logic              w_nibCarry;
   logic              w_lastNib;
   logic [W-1:0]      w_sShNext;

   full_adder_4 u_fullAdder (
      .x     (r_aSh[NIB_W-1:0]),
      .y     (r_bSh[NIB_W-1:0]),
      .c_in  (r_carry),
      .s     (w_nibSum),
      .c_out (w_nibCarry)
   );

   assign w_lastNib = (r_cnt == CW'(NIBBLES - 1));
   // New nibble enters at the top so that after NIBBLES shifts the sum is LSB-first aligned.
   assign w_sShNext = W'({w_nibSum, r_sSh} >> NIB_W);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_nextState = RUN;
         end
         RUN: begin
            if (w_lastNib) w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_sSh   <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cOut  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_aSh   <= a;
                  r_bSh   <= b;
                  r_carry <= c_in;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_aSh   <= r_aSh >> NIB_W;
               r_bSh   <= r_bSh >> NIB_W;
               r_sSh   <= w_sShNext;
               r_carry <= w_nibCarry;
               r_cnt   <= r_cnt + CW'(1);
               if (w_lastNib) begin
                  r_s    <= w_sShNext;
                  r_cOut <= w_nibCarry;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NSA_SIGNED_OVF_EN
   logic r_ovf;

   // On the last nibble the low nibble of a_sh/b_sh holds operand bits W-1..W-4.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && w_lastNib) begin
         r_ovf <= (r_aSh[NIB_W-1] == r_bSh[NIB_W-1]) && (w_nibSum[NIB_W-1] != r_aSh[NIB_W-1]);
      end
   end

   assign ovf = r_ovf;
`endif

   assign s     = r_s;
   assign c_out = r_cOut;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4;
// ovf checks are compiled in with NSA_SIGNED_OVF_EN.
module tb_nibble_serial_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  s;
   logic          c_out;
`ifdef NSA_SIGNED_OVF_EN
   logic          ovf;
`endif

   int checks   = 0;
   int failures = 0;

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
`ifdef NSA_SIGNED_OVF_EN
      .ovf       (ovf),
`endif
      .c_out     (c_out)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Accept one operand set, wait (bounded) for the result and check latency, sum and carry.
   task automatic applyStimulus(input string tag, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                input logic cIn, input logic [W-1:0] expS, input logic expC);
      int lat;
      lat = 0;
      @(negedge clock);
      a        = aIn;
      b        = bIn;
      c_in     = cIn;
      in_valid = 1'b1;
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      c_in     = 1'b0;
      while (lat < 20 && !out_valid) begin
         lat++;
         @(posedge clock);
         #1;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
      checkOutput({tag, "_s"}, 32'(s), 32'(expS));
      checkOutput({tag, "_c_out"}, 32'(c_out), 32'(expC));
   endtask

   task automatic completeHandshake(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic checkOvf(input string tag, input logic expOvf);
`ifdef NSA_SIGNED_OVF_EN
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
`else
      if (expOvf === 1'bx) $display("[TB] %s: unexpected unknown ovf expectation", tag);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic sawValid;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      #1;
      checkOutput("por_in_ready", 32'(in_ready), 32'd1);
      checkOutput("por_out_valid", 32'(out_valid), 32'd0);
      checkOutput("por_s", 32'(s), 32'd0);
      checkOutput("por_c_out", 32'(c_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      checkOvf("add1234", 1'b0);
      completeHandshake("add1234");
      checkOutput("add1234_held_s", 32'(s), 32'h5555);

      // Asynchronous reset away from any clock edge.
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_idle_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_idle_s", 32'(s), 32'd0);
      checkOutput("rst_idle_c_out", 32'(c_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      checkOvf("wrap", 1'b0);
      completeHandshake("wrap");
      applyStimulus("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
      checkOvf("cin_only", 1'b0);
      completeHandshake("cin_only");

      applyStimulus("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
      checkOvf("pos_ovf", 1'b1);
      completeHandshake("pos_ovf");
      applyStimulus("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
      checkOvf("neg_ovf", 1'b1);
      completeHandshake("neg_ovf");

      // Backpressure with an intruding in_valid during RUN and DONE.
      begin
         int lat;
         lat = 0;
         @(negedge clock);
         a        = 16'h0F0F;
         b        = 16'h0101;
         c_in     = 1'b1;
         in_valid = 1'b1;
         @(posedge clock);
         #1;
         a    = 16'h0001;
         b    = 16'h0000;
         c_in = 1'b0;
         checkOutput("bp_run_in_ready", 32'(in_ready), 32'd0);
         while (lat < 20 && !out_valid) begin
            lat++;
            @(posedge clock);
            #1;
         end
         checkOutput("bp_latency", 32'(lat), 32'(NIBBLES));
         checkOutput("bp_s", 32'(s), 32'h1011);
         checkOutput("bp_c_out", 32'(c_out), 32'd0);
         for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("bp_hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_s", 32'(s), 32'h1011);
            checkOutput("bp_hold_c_out", 32'(c_out), 32'd0);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
         end
         @(negedge clock);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clock);
         #1;
         out_ready = 1'b0;
         checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
         checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
         checkOutput("bp_release_s", 32'(s), 32'h1011);
         @(posedge clock);
         #1;
         checkOutput("bp_still_idle", 32'(in_ready), 32'd1);
      end

      // Reset during the second RUN cycle aborts the operation.
      @(negedge clock);
      a        = 16'hAAAA;
      b        = 16'h5555;
      c_in     = 1'b0;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_s", 32'(s), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset    = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
      applyStimulus("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
      checkOvf("after_abort", 1'b0);
      completeHandshake("after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
